// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl
// Turns debounced key pulses into the CPU state-update enable for the
// single-cycle CPU debug path: halt, single step, free run, fixed-length
// burst and a PC breakpoint. Status outputs feed the LED / 7-seg display.
module debug_step_ctrl #(
    parameter int STEP_W = 8,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_pulse,
    input  logic              run_pulse,
    input  logic              burst_pulse,
    input  logic [STEP_W-1:0] burst_len,
    input  logic              cnt_clr,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [31:0]       instr_cnt,
    output logic              bp_hit
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [STEP_W-1:0] remaining_reg, remaining_next;
    logic              skip_reg, skip_next;
    logic              bp_hit_reg, bp_hit_next;
    logic [31:0]       instr_cnt_reg, instr_cnt_next;
    logic              bp_match;
    logic              cpu_en_int;

    // Breakpoint compare and enable: only registers and pc, never the pulses,
    // so the enable cannot glitch on a key pulse.
    always_comb begin
        bp_match   = ((state_reg == ST_RUN) || (state_reg == ST_BURST)) &&
                     bp_en && (pc == bp_addr) && !skip_reg;
        cpu_en_int = (state_reg != ST_HALT) && !bp_match;
    end

    // Command decode and next-state logic; run > burst > step in HALT.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        skip_next      = skip_reg;
        bp_hit_next    = bp_hit_reg;

        unique case (state_reg)
            ST_HALT: begin
                if (run_pulse) begin
                    state_next  = ST_RUN;
                    skip_next   = 1'b1;
                    bp_hit_next = 1'b0;
                end else if (burst_pulse) begin
                    // A zero-length burst is swallowed whole, including any
                    // step pulse that arrived with it.
                    if (burst_len != '0) begin
                        state_next     = ST_BURST;
                        remaining_next = burst_len;
                        skip_next      = 1'b1;
                        bp_hit_next    = 1'b0;
                    end
                end else if (step_pulse) begin
                    state_next  = ST_STEP;
                    bp_hit_next = 1'b0;
                end
            end

            ST_STEP: begin
                state_next = ST_HALT;
            end

            ST_RUN: begin
                if (bp_match) begin
                    state_next  = ST_HALT;
                    bp_hit_next = 1'b1;
                end else if (run_pulse) begin
                    state_next = ST_HALT;
                end
                if (cpu_en_int) begin
                    skip_next = 1'b0;
                end
            end

            ST_BURST: begin
                if (bp_match) begin
                    state_next     = ST_HALT;
                    remaining_next = '0;
                    bp_hit_next    = 1'b1;
                end else if (run_pulse) begin
                    state_next     = ST_HALT;
                    remaining_next = '0;
                end else if (cpu_en_int) begin
                    remaining_next = remaining_reg - STEP_W'(1);
                    if (remaining_reg == STEP_W'(1)) begin
                        state_next = ST_HALT;
                    end
                end
                if (cpu_en_int) begin
                    skip_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // Retired-instruction counter; a clear beats a coincident increment.
    always_comb begin
        instr_cnt_next = instr_cnt_reg;
        if (cnt_clr) begin
            instr_cnt_next = '0;
        end else if (cpu_en_int) begin
            instr_cnt_next = instr_cnt_reg + 32'd1;
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_HALT;
            remaining_reg <= '0;
            skip_reg      <= 1'b0;
            bp_hit_reg    <= 1'b0;
            instr_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            skip_reg      <= skip_next;
            bp_hit_reg    <= bp_hit_next;
            instr_cnt_reg <= instr_cnt_next;
        end
    end

    // Status outputs.
    always_comb begin
        cpu_en    = cpu_en_int;
        halted    = (state_reg == ST_HALT);
        state     = state_reg;
        instr_cnt = instr_cnt_reg;
        bp_hit    = bp_hit_reg;
    end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Testbench for debug_step_ctrl: a vector table of per-cycle inputs and
// expected outputs, plus hand sequences for reset and burst/abort counting.
module tb_debug_step_ctrl;

    logic        clk;
    logic        rst;
    logic        step_pulse;
    logic        run_pulse;
    logic        burst_pulse;
    logic [7:0]  burst_len;
    logic        cnt_clr;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic [31:0] instr_cnt;
    logic        bp_hit;

    int checks   = 0;
    int failures = 0;

    debug_step_ctrl #(.STEP_W(8), .PC_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .step_pulse  (step_pulse),
        .run_pulse   (run_pulse),
        .burst_pulse (burst_pulse),
        .burst_len   (burst_len),
        .cnt_clr     (cnt_clr),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .pc          (pc),
        .cpu_en      (cpu_en),
        .halted      (halted),
        .state       (state),
        .instr_cnt   (instr_cnt),
        .bp_hit      (bp_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic        burst;
        logic        step;
        logic [7:0]  len;
        logic        clr;
        logic        bpe;
        logic [31:0] bpa;
        logic [31:0] pcv;
        logic        exp_en;
        logic        exp_halted;
        logic [1:0]  exp_state;
        logic [31:0] exp_cnt;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int b, input int s, input int len,
                       input int clr, input int bpe, input logic [31:0] bpa,
                       input logic [31:0] pcv, input int en, input int h,
                       input int st, input logic [31:0] cnt, input int hit);
        vec_t v;
        v.run        = r[0];
        v.burst      = b[0];
        v.step       = s[0];
        v.len        = 8'(len);
        v.clr        = clr[0];
        v.bpe        = bpe[0];
        v.bpa        = bpa;
        v.pcv        = pcv;
        v.exp_en     = en[0];
        v.exp_halted = h[0];
        v.exp_state  = 2'(st);
        v.exp_cnt    = cnt;
        v.exp_hit    = hit[0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        step_pulse  = 1'b0;
        run_pulse   = 1'b0;
        burst_pulse = 1'b0;
        burst_len   = 8'd0;
        cnt_clr     = 1'b0;
        bp_en       = 1'b0;
        bp_addr     = 32'd0;
        pc          = 32'd0;
    endtask

    task automatic chk_status(input string tag, input int en, input int h,
                              input int st, input logic [31:0] cnt, input int hit);
        chk({tag, " cpu_en"}, 32'(cpu_en), 32'(en));
        chk({tag, " halted"}, 32'(halted), 32'(h));
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " instr_cnt"}, instr_cnt, cnt);
        chk({tag, " bp_hit"}, 32'(bp_hit), 32'(hit));
    endtask

    // Issue a burst and count enables until halted; optionally abort with
    // run_pulse during the abort_at-th enable cycle.
    task automatic burst_seq(input string tag, input int len, input int abort_at,
                             input int exp_n, input logic [31:0] exp_cnt);
        int n;
        bit done;
        n = 0;
        done = 0;
        @(negedge clk);
        burst_pulse = 1'b1;
        burst_len   = 8'(len);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            burst_pulse = 1'b0;
            run_pulse   = 1'b0;
            #1;
            if (halted) begin
                done = 1;
            end else begin
                if (cpu_en) n++;
                if (abort_at != 0 && n == abort_at) run_pulse = 1'b1;
            end
        end
        run_pulse = 1'b0;
        chk({tag, " finished"}, 32'(done), 32'd1);
        chk({tag, " enables"}, 32'(n), 32'(exp_n));
        chk({tag, " instr_cnt"}, instr_cnt, exp_cnt);
        $display("burst %s len=%0d abort_at=%0d enables=%0d instr_cnt=%0d",
                 tag, len, abort_at, n, instr_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();

        //   r b s len clr bpe bpa pc      | en h st cnt hit
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 0, 0); // 0 idle
        add(0,0,1,0, 0, 0, 0,    0,        0,1,0, 0, 0); // 1 step
        add(0,0,1,0, 0, 0, 0,    0,        1,0,1, 0, 0); // 2 step in STEP ignored
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 1, 0);
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 1, 0);
        add(0,0,1,0, 0, 0, 0,    0,        0,1,0, 1, 0); // 5 step
        add(0,0,0,0, 0, 0, 0,    0,        1,0,1, 1, 0);
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 2, 0);
        add(1,0,1,0, 0, 0, 0,    0,        0,1,0, 2, 0); // 8 run+step -> RUN
        add(0,0,0,0, 0, 0, 0,    0,        1,0,2, 2, 0);
        add(0,0,0,0, 0, 0, 0,    0,        1,0,2, 3, 0);
        add(1,0,0,0, 0, 0, 0,    0,        1,0,2, 4, 0); // 11 run -> HALT
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 5, 0);
        add(0,1,1,3, 0, 0, 0,    0,        0,1,0, 5, 0); // 13 burst+step -> BURST 3
        add(0,0,1,0, 0, 0, 0,    0,        1,0,3, 5, 0);
        add(0,1,0,7, 0, 0, 0,    0,        1,0,3, 6, 0);
        add(0,0,0,0, 0, 0, 0,    0,        1,0,3, 7, 0);
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 8, 0);
        add(0,1,1,0, 0, 0, 0,    0,        0,1,0, 8, 0); // 18 burst len 0 + step
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 8, 0);
        add(0,0,0,0, 1, 0, 0,    0,        0,1,0, 8, 0); // 20 clear
        add(0,0,0,0, 0, 0, 0,    0,        0,1,0, 0, 0);
        add(1,0,0,0, 0, 1, 32'hC, 32'h0,   0,1,0, 0, 0); // 22 run, bp at 0x0C
        add(0,0,0,0, 0, 1, 32'hC, 32'h0,   1,0,2, 0, 0);
        add(0,0,0,0, 0, 1, 32'hC, 32'h4,   1,0,2, 1, 0);
        add(0,0,0,0, 0, 1, 32'hC, 32'h8,   1,0,2, 2, 0);
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   0,0,2, 3, 0); // 26 bp match
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   0,1,0, 3, 1);
        add(1,0,0,0, 0, 1, 32'hC, 32'hC,   0,1,0, 3, 1); // 28 rerun at bp
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   1,0,2, 3, 0); // 29 skip executes 0x0C
        add(0,0,0,0, 0, 1, 32'hC, 32'h10,  1,0,2, 4, 0);
        add(1,0,0,0, 0, 1, 32'hC, 32'hC,   0,0,2, 5, 0); // 31 run + bp match
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   0,1,0, 5, 1);
        add(0,1,0,5, 0, 1, 32'hC, 32'hC,   0,1,0, 5, 1); // 33 burst at bp
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   1,0,3, 5, 0);
        add(0,0,0,0, 0, 1, 32'hC, 32'h10,  1,0,3, 6, 0);
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   0,0,3, 7, 0); // 36 bp in burst
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   0,1,0, 7, 1);
        add(0,0,1,0, 0, 1, 32'hC, 32'hC,   0,1,0, 7, 1); // 38 step at bp
        add(0,0,0,0, 0, 1, 32'hC, 32'hC,   1,0,1, 7, 0); // 39 no bp check in STEP
        add(0,0,0,0, 1, 1, 32'hC, 32'h0,   0,1,0, 8, 0); // 40 clear
        add(0,0,0,0, 0, 1, 32'hC, 32'h0,   0,1,0, 0, 0);
        add(0,0,1,0, 0, 1, 32'hC, 32'h0,   0,1,0, 0, 0); // 42 step
        add(0,0,0,0, 1, 1, 32'hC, 32'h0,   1,0,1, 0, 0); // 43 clr with cpu_en
        add(0,0,0,0, 0, 1, 32'hC, 32'h0,   0,1,0, 0, 0);

        // Reset state while reset is held.
        repeat (3) @(negedge clk);
        #1;
        chk_status("reset", 0, 1, 0, 32'd0, 0);
        $display("reset: cpu_en=%0b halted=%0b state=%0d instr_cnt=%0d bp_hit=%0b",
                 cpu_en, halted, state, instr_cnt, bp_hit);
        rst = 1'b1;

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run_pulse   = vecs[i].run;
            burst_pulse = vecs[i].burst;
            step_pulse  = vecs[i].step;
            burst_len   = vecs[i].len;
            cnt_clr     = vecs[i].clr;
            bp_en       = vecs[i].bpe;
            bp_addr     = vecs[i].bpa;
            pc          = vecs[i].pcv;
            #1;
            chk_status($sformatf("row%0d", i), 32'(vecs[i].exp_en),
                       32'(vecs[i].exp_halted), 32'(vecs[i].exp_state),
                       vecs[i].exp_cnt, 32'(vecs[i].exp_hit));
            $display("row %0d: r=%0b b=%0b s=%0b len=%0d clr=%0b pc=%0h -> en=%0b h=%0b st=%0d cnt=%0d hit=%0b",
                     i, run_pulse, burst_pulse, step_pulse, burst_len, cnt_clr, pc,
                     cpu_en, halted, state, instr_cnt, bp_hit);
        end
        @(negedge clk);
        clear_inputs();

        // Reset asserted mid-burst after 4 retired instructions.
        @(negedge clk);
        burst_pulse = 1'b1;
        burst_len   = 8'd10;
        @(negedge clk);
        burst_pulse = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midburst pre-reset instr_cnt", instr_cnt, 32'd4);
        chk("midburst pre-reset cpu_en", 32'(cpu_en), 32'd1);
        rst = 1'b0;
        #1;
        chk_status("midburst reset", 0, 1, 0, 32'd0, 0);
        $display("midburst reset: cpu_en=%0b halted=%0b state=%0d instr_cnt=%0d",
                 cpu_en, halted, state, instr_cnt);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_status("post-reset idle", 0, 1, 0, 32'd0, 0);
        end

        // Full burst of 5, then a burst of 5 aborted on its 3rd enable.
        burst_seq("full5", 5, 0, 5, 32'd5);
        burst_seq("abort3", 5, 3, 3, 32'd8);
        #1;
        chk("abort3 halted", 32'(halted), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_step_ctrl.md
# debug_step_ctrl

Converts single-cycle command pulses from the board key debouncers into a CPU execution enable for the single-cycle CPU debug path. Supports halt, single-step, free run, fixed-length burst, and a PC breakpoint. It sits between the debounced key pulses and the CPU register-update enable, and exports status for the LED/seven-segment debug display.

## Interface
Parameters:
- STEP_W, 8, width of burst length and remaining-count register
- PC_W, 32, width of pc and bp_addr

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- step_pulse  in  1  one-cycle high pulse: execute one instruction
- run_pulse  in  1  one-cycle high pulse: toggle run/halt; aborts burst
- burst_pulse  in  1  one-cycle high pulse: execute burst_len instructions
- burst_len  in  STEP_W  burst length, sampled on accepted burst_pulse
- cnt_clr  in  1  one-cycle high pulse: clear instr_cnt
- bp_en  in  1  breakpoint enable (level)
- bp_addr  in  PC_W  breakpoint address
- pc  in  PC_W  current CPU PC (registered CPU state)
- cpu_en  out  1  CPU state-update enable; one instruction retires per high cycle
- halted  out  1  high when FSM is in HALT
- state  out  2  FSM state encoding
- instr_cnt  out  32  instructions retired since reset/clear
- bp_hit  out  1  high after a breakpoint halt

## Operation
- States: HALT=2'd0, STEP=2'd1, RUN=2'd2, BURST=2'd3. Reset state HALT.
- Command priority when several pulses are high in one cycle: run_pulse > burst_pulse > step_pulse; lower-priority pulses that cycle are dropped.
- HALT: run_pulse -> RUN; burst_pulse with burst_len != 0 -> BURST, remaining <= burst_len; burst_pulse with burst_len == 0 ignored (stays HALT, nothing else changes); step_pulse -> STEP.
- STEP: lasts exactly one cycle, then HALT unconditionally. Breakpoint is not checked in STEP. All pulses in the STEP cycle are ignored.
- RUN: run_pulse -> HALT. step_pulse, burst_pulse ignored.
- BURST: remaining decrements on every cpu_en cycle; when remaining == 1 and cpu_en, -> HALT. run_pulse -> HALT (abort, remaining discarded). step_pulse, burst_pulse ignored.
- Breakpoint (RUN/BURST only): bp_match = bp_en && (pc == bp_addr) && !skip. On bp_match: cpu_en forced 0 that cycle, next state HALT, bp_hit <= 1. If run_pulse coincides, the result is the same: HALT, and bp_hit is set.
- skip flag: set on entry to RUN/BURST, cleared after first cpu_en cycle, so a run started at pc == bp_addr executes that instruction.
- cpu_en = (state != HALT) && !bp_match. Depends only on registers and pc; no glitch path from the pulse inputs.
- halted = (state == HALT).
- instr_cnt: +1 each cycle cpu_en is high; wraps 32'hFFFFFFFF -> 0. cnt_clr takes priority over increment, giving 0.
- bp_hit: cleared when any command is accepted out of HALT; otherwise holds.
- Asynchronous reset at any time, including mid-burst, returns: state=HALT, cpu_en=0, halted=1, instr_cnt=0, bp_hit=0, remaining=0, skip=0.

## Timing
- A pulse sampled high at edge n changes state at edge n. cpu_en is first high in the cycle after that edge, i.e. a latency of one cycle.
- STEP: cpu_en high for exactly 1 cycle per accepted step_pulse.
- BURST N: cpu_en high for exactly N consecutive cycles, unless a breakpoint halts it or run_pulse aborts it. halted rises in the cycle after the last enable.
- RUN abort: run_pulse sampled at edge n makes cpu_en low from cycle n+1.
- instr_cnt reflects a retired instruction one cycle after its cpu_en cycle.

## Test plan
- Reset: hold rst=0 mid-BURST (burst_len=10, 4 retired) -> cpu_en=0, halted=1, state=0, instr_cnt=0, bp_hit=0. After release, nothing happens until a pulse arrives.
- Step: three step_pulses spaced 5 cycles apart -> three single-cycle cpu_en pulses, each starting 1 cycle after its step_pulse. instr_cnt=3. A step_pulse in the STEP cycle is ignored.
- Burst: burst_len=5 -> exactly 5 consecutive cpu_en cycles, then halted=1, instr_cnt=5. burst_len=0 -> no cpu_en, state stays 0. run_pulse on the 3rd enable cycle -> 3 retired.
- Breakpoint: bp_en=1, bp_addr=0x0C, pc advancing by 4 from 0, run_pulse -> 3 retired (pc 0,4,8), cpu_en=0 at pc=0x0C, halted=1, bp_hit=1. A second run_pulse at pc=0x0C executes 0x0C (skip) and clears bp_hit.
- Simultaneous: run_pulse+step_pulse in HALT -> RUN. burst_pulse+step_pulse -> BURST. run_pulse coinciding with bp_match -> HALT, bp_hit=1.
- Counter: preload to 32'hFFFFFFFE via 2^32-2 enables (or force), then 3 steps -> instr_cnt wraps to 1. cnt_clr coinciding with cpu_en -> 0.
